mod_n_counter: RTL and testbench

Parametrised synchronous up/down modulo-N counter. It is the general-purpose successor to the team's 4-bit 74LS161-style counter. It keeps that part's behaviour: parallel load, ENP/ENT enables and a cascadable ripple-carry output. It adds configurable width and modulus, count direction, synchronous clear and a registered wrap pulse. It serves as the counting primitive for timers, prescalers and BCD display chains, and cascades stage-to-stage through ENT/RCO.

---
 rtl/mod_n_counter.sv | 85 ++++++++
 tb/tb_mod_n_counter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// mod_n_counter: parametrised synchronous up/down modulo-N counter.
// Keeps 74LS161-style parallel load, ENP/ENT enables and cascadable RCO.
// Adds width/modulus parameters, direction, synchronous clear and a registered WRAP pulse.
module mod_n_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             SCLR_n,
    input  logic             LOAD_n,
    input  logic             UP,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             WRAP
);

    // Largest in-range count. Computed at 64 bits so MODULUS = 2**32 is representable.
    localparam longint unsigned MaxCount = MODULUS - 64'd1;
    localparam logic [WIDTH:0]   MaxExt  = MaxCount[WIDTH:0];
    localparam logic [WIDTH-1:0] MaxVal  = MaxCount[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] term_val;

    // Range comparisons use one extra bit so MODULUS = 2**WIDTH compares correctly.
    assign q_ext = {1'b0, q_q};

    // Next-state: clear, then load, then count, else hold; WRAP only on a counting wrap.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!SCLR_n) begin
            q_d = '0;
        end else if (!LOAD_n) begin
            q_d = D;
        end else if (ENP && ENT) begin
            if (UP) begin
                if (q_ext < MaxExt) begin
                    q_d = q_q + WIDTH'(1);
                end else begin
                    // Covers both the terminal count and out-of-range loaded values.
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (q_ext == '0) begin
                    q_d    = MaxVal;
                    wrap_d = 1'b1;
                end else if (q_ext > MaxExt) begin
                    // Out-of-range recovery: snap into range without flagging a wrap.
                    q_d = MaxVal;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal-count detect; combinational so cascaded stages see it in the same cycle.
    always_comb begin
        term_val = UP ? MaxVal : '0;
        RCO      = ENT & (q_q == term_val);
    end

    assign Q    = q_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: a MODULUS=10 low digit cascaded into a
// MODULUS=10 high digit, plus a MODULUS=16 instance, all checked against a
// behavioural model.
module tb_mod_n_counter;

    logic       clk = 1'b0;
    logic       clr_n, sclr_n, load_n, up, enp, ent;
    logic [3:0] d;
    logic [3:0] q_lo, q_hi, q_16;
    logic       rco_lo, rco_hi, rco_16;
    logic       wrap_lo, wrap_hi, wrap_16;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_lo_q, m_hi_q, m_16_q;
    bit m_lo_w, m_hi_w, m_16_w;

    always #5 clk = ~clk;

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .CLK(clk), .CLR_n(clr_n), .SCLR_n(sclr_n), .LOAD_n(load_n), .UP(up),
        .ENP(enp), .ENT(ent), .D(d), .Q(q_lo), .RCO(rco_lo), .WRAP(wrap_lo)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .CLK(clk), .CLR_n(clr_n), .SCLR_n(sclr_n), .LOAD_n(load_n), .UP(up),
        .ENP(enp), .ENT(rco_lo), .D(d), .Q(q_hi), .RCO(rco_hi), .WRAP(wrap_hi)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(16)) u_16 (
        .CLK(clk), .CLR_n(clr_n), .SCLR_n(sclr_n), .LOAD_n(load_n), .UP(up),
        .ENP(enp), .ENT(ent), .D(d), .Q(q_16), .RCO(rco_16), .WRAP(wrap_16)
    );

    // Terminal-count output expected from the model.
    function automatic bit model_rco(input int q, input int m, input bit e_t);
        return e_t && (q == (up ? m - 1 : 0));
    endfunction

    // One clock of behaviour for a modulus-m counter.
    task automatic model_next(inout int q, inout bit w, input int m, input bit e_t);
        w = 1'b0;
        if (!sclr_n) q = 0;
        else if (!load_n) q = int'(d);
        else if (enp && e_t) begin
            if (up) begin
                if (q + 1 >= m) begin q = 0; w = 1'b1; end
                else q = q + 1;
            end else begin
                if (q == 0) begin q = m - 1; w = 1'b1; end
                else if (q >= m) q = m - 1;
                else q = q - 1;
            end
        end
    endtask

    task automatic model_clear();
        m_lo_q = 0; m_hi_q = 0; m_16_q = 0;
        m_lo_w = 0; m_hi_w = 0; m_16_w = 0;
    endtask

    // Apply one rising edge, advance the model, return at the falling edge.
    task automatic step();
        bit hi_ent;
        hi_ent = model_rco(m_lo_q, 10, ent);
        @(posedge clk);
        if (!clr_n) model_clear();
        else begin
            model_next(m_lo_q, m_lo_w, 10, ent);
            model_next(m_hi_q, m_hi_w, 10, hi_ent);
            model_next(m_16_q, m_16_w, 16, ent);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit s, input bit l, input bit u, input bit p, input bit t,
                         input logic [3:0] dv);
        sclr_n = s; load_n = l; up = u; enp = p; ent = t; d = dv;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 1, 1, 4'd3);
        clr_n = 1'b0;
        model_clear();
        #2;
        checks++;
        if (q_lo !== 4'd0 || wrap_lo !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: Q=%0d WRAP=%0b, required Q=0 WRAP=0", q_lo, wrap_lo);
        end
        checks++;
        if (rco_lo !== 1'b1) begin
            errors++;
            $display("FAIL reset_rco_down: RCO=%0b, required 1", rco_lo);
        end
        up = 1'b1;
        #1;
        checks++;
        if (rco_lo !== 1'b0) begin
            errors++;
            $display("FAIL reset_rco_up: RCO=%0b, required 0", rco_lo);
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_count_up();
        drive(1, 1, 1, 1, 1, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (q_lo !== 4'(i % 10) || q_lo !== 4'(m_lo_q)) begin
                errors++;
                $display("FAIL count_up_q[%0d]: Q=%0d, required %0d", i, q_lo, i % 10);
            end
            checks++;
            if (wrap_lo !== (i == 10) || rco_lo !== (i % 10 == 9)) begin
                errors++;
                $display("FAIL count_up_flags[%0d]: WRAP=%0b RCO=%0b, required WRAP=%0b RCO=%0b",
                         i, wrap_lo, rco_lo, i == 10, i % 10 == 9);
            end
        end
    endtask

    task automatic test_count_down();
        drive(0, 1, 1, 1, 1, 4'd0);
        step();
        drive(1, 1, 0, 1, 1, 4'd0);
        #1;
        checks++;
        if (rco_lo !== 1'b1) begin
            errors++;
            $display("FAIL down_rco_at_zero: RCO=%0b, required 1", rco_lo);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q_lo !== 4'(9 - i) || wrap_lo !== (i == 0) || rco_lo !== 1'b0) begin
                errors++;
                $display("FAIL count_down[%0d]: Q=%0d WRAP=%0b RCO=%0b, required Q=%0d WRAP=%0b RCO=0",
                         i, q_lo, wrap_lo, rco_lo, 9 - i, i == 0);
            end
        end
    endtask

    task automatic test_out_of_range();
        drive(1, 0, 1, 1, 1, 4'd13);
        step();
        checks++;
        if (q_lo !== 4'd13 || wrap_lo !== 1'b0) begin
            errors++;
            $display("FAIL oor_load: Q=%0d WRAP=%0b, required Q=13 WRAP=0", q_lo, wrap_lo);
        end
        drive(1, 1, 1, 1, 1, 4'd0);
        step();
        checks++;
        if (q_lo !== 4'd0 || wrap_lo !== 1'b1) begin
            errors++;
            $display("FAIL oor_up: Q=%0d WRAP=%0b, required Q=0 WRAP=1", q_lo, wrap_lo);
        end
        drive(1, 0, 0, 1, 1, 4'd13);
        step();
        drive(1, 1, 0, 1, 1, 4'd0);
        step();
        checks++;
        if (q_lo !== 4'd9 || wrap_lo !== 1'b0) begin
            errors++;
            $display("FAIL oor_down: Q=%0d WRAP=%0b, required Q=9 WRAP=0", q_lo, wrap_lo);
        end
    endtask

    task automatic test_priority();
        drive(1, 0, 1, 1, 1, 4'd3);
        step();
        drive(0, 0, 1, 1, 1, 4'd5);
        step();
        checks++;
        if (q_lo !== 4'd0) begin
            errors++;
            $display("FAIL prio_clear_over_load: Q=%0d, required 0", q_lo);
        end
        // Load from 9 with counting enabled would otherwise wrap.
        drive(1, 0, 1, 1, 1, 4'd9);
        step();
        drive(1, 0, 1, 1, 1, 4'd5);
        step();
        checks++;
        if (q_lo !== 4'd5 || wrap_lo !== 1'b0) begin
            errors++;
            $display("FAIL prio_load_over_count: Q=%0d WRAP=%0b, required Q=5 WRAP=0",
                     q_lo, wrap_lo);
        end
        drive(1, 1, 1, 0, 1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q_lo !== 4'd5 || wrap_lo !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: Q=%0d WRAP=%0b, required Q=5 WRAP=0", i, q_lo, wrap_lo);
            end
        end
    endtask

    task automatic test_cascade();
        drive(0, 1, 1, 1, 1, 4'd0);
        step();
        drive(1, 1, 1, 1, 1, 4'd0);
        for (int n = 1; n <= 100; n++) begin
            step();
            checks++;
            if (q_lo !== 4'((n % 100) % 10) || q_hi !== 4'((n % 100) / 10)) begin
                errors++;
                $display("FAIL cascade_count[%0d]: hi=%0d lo=%0d, required hi=%0d lo=%0d",
                         n, q_hi, q_lo, (n % 100) / 10, (n % 100) % 10);
            end
            if (n == 99) begin
                checks++;
                if (rco_lo !== 1'b1 || rco_hi !== 1'b1) begin
                    errors++;
                    $display("FAIL cascade_rco_99: RCO lo=%0b hi=%0b, required 1 1", rco_lo, rco_hi);
                end
            end
            if (n == 100) begin
                checks++;
                if (wrap_lo !== 1'b1 || wrap_hi !== 1'b1) begin
                    errors++;
                    $display("FAIL cascade_wrap_00: WRAP lo=%0b hi=%0b, required 1 1",
                             wrap_lo, wrap_hi);
                end
            end
        end
    endtask

    task automatic test_async_clear();
        drive(0, 1, 1, 1, 1, 4'd0);
        step();
        drive(1, 1, 1, 1, 1, 4'd0);
        for (int i = 0; i < 7; i++) step();
        #2;
        clr_n = 1'b0;
        #1;
        checks++;
        if (q_lo !== 4'd0 || wrap_lo !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: Q=%0d WRAP=%0b, required Q=0 WRAP=0", q_lo, wrap_lo);
        end
        @(negedge clk);
        step();
        step();
        checks++;
        if (q_lo !== 4'd0) begin
            errors++;
            $display("FAIL async_hold: Q=%0d, required 0", q_lo);
        end
        clr_n = 1'b1;
        step();
        checks++;
        if (q_lo !== 4'd1) begin
            errors++;
            $display("FAIL async_resume: Q=%0d, required 1", q_lo);
        end
    endtask

    task automatic test_full_range();
        drive(0, 1, 1, 1, 1, 4'd0);
        step();
        drive(1, 1, 1, 1, 1, 4'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if (q_16 !== 4'(i % 16) || wrap_16 !== (i == 16) || rco_16 !== (i == 15)) begin
                errors++;
                $display("FAIL full_range[%0d]: Q=%0d WRAP=%0b RCO=%0b, required Q=%0d WRAP=%0b RCO=%0b",
                         i, q_16, wrap_16, rco_16, i % 16, i == 16, i == 15);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 4'($urandom));
            #1;
            checks++;
            if (rco_lo !== model_rco(m_lo_q, 10, ent) ||
                rco_hi !== model_rco(m_hi_q, 10, model_rco(m_lo_q, 10, ent)) ||
                rco_16 !== model_rco(m_16_q, 16, ent)) begin
                errors++;
                $display("FAIL rand_rco[%0d]: lo=%0b hi=%0b m16=%0b", i, rco_lo, rco_hi, rco_16);
            end
            step();
            checks++;
            if (q_lo !== 4'(m_lo_q) || wrap_lo !== m_lo_w) begin
                errors++;
                $display("FAIL rand_lo[%0d]: Q=%0d WRAP=%0b, required Q=%0d WRAP=%0b",
                         i, q_lo, wrap_lo, m_lo_q, m_lo_w);
            end
            checks++;
            if (q_hi !== 4'(m_hi_q) || wrap_hi !== m_hi_w) begin
                errors++;
                $display("FAIL rand_hi[%0d]: Q=%0d WRAP=%0b, required Q=%0d WRAP=%0b",
                         i, q_hi, wrap_hi, m_hi_q, m_hi_w);
            end
            checks++;
            if (q_16 !== 4'(m_16_q) || wrap_16 !== m_16_w) begin
                errors++;
                $display("FAIL rand_m16[%0d]: Q=%0d WRAP=%0b, required Q=%0d WRAP=%0b",
                         i, q_16, wrap_16, m_16_q, m_16_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_out_of_range();
        test_priority();
        test_cascade();
        test_async_clear();
        test_full_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
